// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the client-facing request/data lines and the transmitter-facing
// outputs of uart_tx_arbiter.
//   master : client/top-level side (drives i_req, i_data; observes the rest)
//   slave  : arbiter side (reads i_req, i_data; drives o_*)
// Signals:
//   i_req      [NUM_CLIENTS]   per-client request level
//   i_data     [8*NUM_CLIENTS] client k's byte at [8k+7:8k]
//   o_ack      [NUM_CLIENTS]   one-hot, one-cycle capture pulse
//   o_owner    [OWNER_W]       index of current/last granted client
//   o_busy                     frame launching or in flight
//   o_tx_data  [8]             transmitter data, held for the whole frame
//   o_tx_start                 one-cycle transmitter start pulse
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_CLIENTS = 4
);
    localparam int OWNER_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_CLIENTS-1:0]   i_req;
    logic [8*NUM_CLIENTS-1:0] i_data;
    logic [NUM_CLIENTS-1:0]   o_ack;
    logic [OWNER_W-1:0]       o_owner;
    logic                     o_busy;
    logic [7:0]               o_tx_data;
    logic                     o_tx_start;

    modport master (
        output i_req,
        output i_data,
        input  o_ack,
        input  o_owner,
        input  o_busy,
        input  o_tx_data,
        input  o_tx_start
    );

    modport slave (
        input  i_req,
        input  i_data,
        output o_ack,
        output o_owner,
        output o_busy,
        output o_tx_data,
        output o_tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_transmitter among NUM_CLIENTS requesters. A winner is
// chosen round-robin, its byte is captured and held on o_tx_data for the
// whole frame, and a one-cycle o_tx_start pulse launches the transmitter.
// The transmitter has no busy output, so frame length is timed locally with
// a down-counter of FRAME_CYCLES.
// Ports:
//   clk      system clock
//   i_reset  asynchronous active-high reset
//   bus      uart_tx_arbiter_if.slave (i_req, i_data in; o_ack, o_owner,
//            o_busy, o_tx_data, o_tx_start out; all outputs registered)
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  when defined, lowest-index requester always
//                              wins and the round-robin pointer is dropped.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_CLIENTS       = 4,
    parameter int BAUD_RATE         = 10000,
    parameter int CLOCK_FREQUENCY   = 100000000,
    parameter int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE,
    parameter int GUARD_CYCLES      = 4,
    parameter int FRAME_CYCLES      = 10 * CYCLES_PER_SAMPLE + GUARD_CYCLES
) (
    input  logic               clk,
    input  logic               i_reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int OWNER_W = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W   = $clog2(FRAME_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic                   busy_q, busy_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    logic [OWNER_W-1:0]     last_q, last_d;
`endif

    // Per-client byte lanes.
    logic [7:0] client_byte [NUM_CLIENTS];
    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_lane
            assign client_byte[gi] = bus.i_data[8*gi +: 8];
        end
    endgenerate

    // Winner selection (combinational, only meaningful when |i_req).
    logic [OWNER_W-1:0] winner;
    logic [7:0]         winner_byte;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (bus.i_req[k]) begin
                winner = OWNER_W'(k);
            end
        end
    end
`else
    always_comb begin
        logic found;
        int   cand;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        // Search starts one past the last grant and wraps, so the previous
        // winner is considered last.
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
            if (!found && bus.i_req[cand]) begin
                winner = OWNER_W'(cand);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        winner_byte = 8'h00;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (winner == OWNER_W'(k)) begin
                winner_byte = client_byte[k];
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q     <= OWNER_W'(NUM_CLIENTS - 1);
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values. ack and start are single-cycle pulses;
    // owner and tx_data persist until the next grant.
    always_comb begin
        count_d    = count_q;
        ack_d      = '0;
        owner_d    = owner_q;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_req) begin
                    tx_data_d = winner_byte;
                    owner_d   = winner;
                    ack_d     = NUM_CLIENTS'(1) << winner;
                    busy_d    = 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                    last_d    = winner;
`endif
                end
            end
            ST_LAUNCH: begin
                tx_start_d = 1'b1;
                count_d    = CNT_W'(FRAME_CYCLES - 1);
            end
            ST_WAIT: begin
                if (count_q == '0) begin
                    busy_d = 1'b0;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_owner    = owner_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_transmitter between NUM_CLIENTS requesters.
- Arbitrates requests round-robin and captures the winner's byte.
- Issues a one-cycle start pulse to the transmitter and holds its data input stable for the whole frame.
- The transmitter has no busy output and re-registers its data input every cycle, so this block times each frame with its own counter.
- Sits between client logic and the uart_transmitter instance; clk and i_reset are shared with the transmitter at top level.

Parameters:
- NUM_CLIENTS, 4: number of requesters, 2..8.
- BAUD_RATE, 10000: line rate in bit/s; must match the transmitter.
- CLOCK_FREQUENCY, 100000000: clk frequency in Hz; must match the transmitter.
- CYCLES_PER_SAMPLE, CLOCK_FREQUENCY/BAUD_RATE: clk cycles per bit (derived).
- GUARD_CYCLES, 4: extra idle cycles per frame; covers the transmitter's 2-cycle input/state lag. Minimum 3.
- FRAME_CYCLES, 10*CYCLES_PER_SAMPLE+GUARD_CYCLES: wait-phase length (derived). Counter width is $clog2(FRAME_CYCLES+1).

Ports:
- clk, input, 1: system clock; the only clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_req, input, NUM_CLIENTS: per-client request level; hold high with stable data until acked.
- i_data, input, 8*NUM_CLIENTS: client k's byte is i_data[8k+7:8k].
- o_ack, output, NUM_CLIENTS: one-hot, one-cycle pulse; the byte was captured.
- o_owner, output, $clog2(NUM_CLIENTS) (min 1): index of the current/last granted client.
- o_busy, output, 1: a frame is launching or in flight.
- o_tx_data, output, 8: connect to the transmitter's i_data; held for the entire frame.
- o_tx_start, output, 1: connect to i_start_transmission; one-cycle pulse.

Behaviour:
- Reset (async, takes effect immediately):
  - Outputs: o_ack=0, o_owner=0, o_busy=0, o_tx_data=0x00, o_tx_start=0.
  - Internal: state=IDLE, count=0, round-robin pointer last=NUM_CLIENTS-1, so client 0 has first priority.
- All outputs are registered.
- FSM state IDLE:
  - At an edge where any i_req is set, pick a winner.
  - Round robin: search from last+1 upward, wrapping; the first set bit wins.
  - Register o_tx_data=byte(winner), o_owner=winner, o_ack=onehot(winner), o_busy=1, last=winner.
  - Go to LAUNCH. If no request, remain in IDLE with outputs unchanged.
- FSM state LAUNCH (1 cycle):
  - At the next edge: o_ack=0, o_tx_start=1, count=FRAME_CYCLES-1.
  - Go to WAIT.
- FSM state WAIT:
  - At each edge o_tx_start=0.
  - If count==0: o_busy=0, go to IDLE. Otherwise count decrements.
- Timing:
  - o_busy is high for FRAME_CYCLES+1 cycles per frame.
  - Minimum spacing between successive o_ack pulses is FRAME_CYCLES+2 cycles.
- o_tx_data and o_owner keep their values after the frame until the next grant.
- Requests arriving while o_busy=1 are not acked. They are evaluated at the first edge in IDLE.
- A request dropped before ack is simply not considered; no state is kept per client.
- Client k's request rises in the same cycle another client is acked: k is served on a later frame in round-robin order.
- Single client requesting continuously: it is re-granted every FRAME_CYCLES+2 cycles.
- o_ack is never asserted for a client whose i_req was low at the granting edge.
- Reset mid-frame: outputs clear at once, and any byte in progress is abandoned.
  - No client sees an ack after reset until a new grant.
  - Reset clearing the transmitter itself is the top level's concern.

Optional Feature:
- Macro UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requesting client always wins. The last pointer is removed; all other behaviour is identical.
- Undefined (default): round robin as above.

Test Plan:
Bench parameters: BAUD_RATE=1000000, CLOCK_FREQUENCY=4000000 (CYCLES_PER_SAMPLE=4), GUARD_CYCLES=4, FRAME_CYCLES=44, NUM_CLIENTS=4.
1. Reset: assert i_reset -> all outputs 0 immediately; no o_ack while i_req=0 for 100 cycles.
2. Single grant: i_req=4'b0100, byte2=0xA5 -> next edge o_ack=4'b0100 for 1 cycle, o_owner=2, o_tx_data=0xA5. o_tx_start pulses the cycle after. o_busy high exactly 45 cycles. With the transmitter attached, o_tx shows a start bit, the 8 data bits of 0xA5, and a stop bit, 4 cycles each.
3. Round robin: i_req=4'b1111 held -> ack order 0,1,2,3,0, acks spaced 46 cycles. With UART_TX_ARB_FIXED_PRIO_EN: 0,0,0,0,0.
4. Late arrival: client 3 raises i_req during client 1's frame -> no ack until o_busy falls. Client 3 is acked at the first IDLE edge after o_busy falls.
5. Mid-frame reset: i_reset pulsed 20 cycles into WAIT -> o_busy, o_tx_data and o_tx_start are 0 at once. With i_req=4'b0011 held, the next grant is client 0.
6. Data hold: change client 2's i_data after its ack -> o_tx_data stays 0xA5 until the next grant.
